// File: rtl/sevenseg_pkg.sv
// Shared types and active-low glyph constants for the seven-segment driver.
package sevenseg_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [3:0] nibble_t;

   // {a,b,c,d,e,f,g}, a at MSB, 0 = segment lit
   localparam seg_t SEG_0     = 7'b0000001;
   localparam seg_t SEG_1     = 7'b1001111;
   localparam seg_t SEG_2     = 7'b0010010;
   localparam seg_t SEG_3     = 7'b0000110;
   localparam seg_t SEG_4     = 7'b1001100;
   localparam seg_t SEG_5     = 7'b0100100;
   localparam seg_t SEG_6     = 7'b0100000;
   localparam seg_t SEG_7     = 7'b0001111;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0000100;
   localparam seg_t SEG_A     = 7'b0001000;
   localparam seg_t SEG_B     = 7'b1100000;
   localparam seg_t SEG_C     = 7'b0110001;
   localparam seg_t SEG_D     = 7'b1000010;
   localparam seg_t SEG_E     = 7'b0110000;
   localparam seg_t SEG_F     = 7'b0111000;
   localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sevenseg_glyph.sv
// Combinational nibble to active-low glyph decoder; codes 10..15 blank unless hex_mode.
module sevenseg_glyph
   import sevenseg_pkg::*;
(
   input  nibble_t nibble,
   input  logic    hex_mode,
   input  logic    blank,
   output seg_t    glyph_c
);

   always_comb begin
      glyph_c = SEG_BLANK;
      if (!blank) begin
         case (nibble)
            4'h0:    glyph_c = SEG_0;
            4'h1:    glyph_c = SEG_1;
            4'h2:    glyph_c = SEG_2;
            4'h3:    glyph_c = SEG_3;
            4'h4:    glyph_c = SEG_4;
            4'h5:    glyph_c = SEG_5;
            4'h6:    glyph_c = SEG_6;
            4'h7:    glyph_c = SEG_7;
            4'h8:    glyph_c = SEG_8;
            4'h9:    glyph_c = SEG_9;
            4'hA:    glyph_c = hex_mode ? SEG_A : SEG_BLANK;
            4'hB:    glyph_c = hex_mode ? SEG_B : SEG_BLANK;
            4'hC:    glyph_c = hex_mode ? SEG_C : SEG_BLANK;
            4'hD:    glyph_c = hex_mode ? SEG_D : SEG_BLANK;
            4'hE:    glyph_c = hex_mode ? SEG_E : SEG_BLANK;
            default: glyph_c = hex_mode ? SEG_F : SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/sevenseg_mux_driver.sv
// Multiplexed common-anode seven-segment driver: shadow-loaded value committed
// at frame wrap, scanned one digit per REFRESH_DIV cycles, active-low outputs.
module sevenseg_mux_driver
   import sevenseg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV   = 12500,
   parameter int unsigned HEX_MODE      = 0,
   parameter int unsigned BLANK_LEADING = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    enable,
   output seg_t                    seg,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned VAL_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("sevenseg_mux_driver: NUM_DIGITS must be 1..8");
   end
   if (REFRESH_DIV < 2) begin : g_bad_refresh_div
      $error("sevenseg_mux_driver: REFRESH_DIV must be >= 2");
   end
   if (HEX_MODE > 1 || BLANK_LEADING > 1) begin : g_bad_mode
      $error("sevenseg_mux_driver: HEX_MODE and BLANK_LEADING must be 0 or 1");
   end

   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic [VAL_W-1:0]      shd_val, shd_val_nxt, disp_val, disp_val_nxt;
   logic [NUM_DIGITS-1:0] shd_dp, shd_dp_nxt, disp_dp, disp_dp_nxt;
   logic                  pending, pending_nxt;
   seg_t                  seg_nxt;
   logic                  dp_n_nxt;
   logic [NUM_DIGITS-1:0] an_nxt;
   logic                  frame_done_nxt;

   logic                  tick_c, commit_c;
   logic [NUM_DIGITS-1:0] lead_zero_c;
   nibble_t               nib_sel_c;
   logic                  blank_sel_c;
   seg_t                  glyph_c;

   assign tick_c   = (cnt == CNT_LAST);
   assign commit_c = tick_c && (idx == IDX_LAST);

   // lead_zero_c[i]: nibbles NUM_DIGITS-1 down to i are all zero
   always_comb begin
      logic run;
      run         = 1'b1;
      lead_zero_c = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         run            = run & (disp_val[4*i +: 4] == 4'h0);
         lead_zero_c[i] = run;
      end
   end

   assign nib_sel_c   = disp_val[4*idx +: 4];
   assign blank_sel_c = (BLANK_LEADING != 0) && (idx != '0) && lead_zero_c[idx];

   sevenseg_glyph u_glyph (
      .nibble   (nib_sel_c),
      .hex_mode (HEX_MODE != 0),
      .blank    (blank_sel_c),
      .glyph_c  (glyph_c)
   );

   // Next-state: scan counters, shadow/commit path, output decode
   always_comb begin
      cnt_nxt        = tick_c ? '0 : cnt + CNT_W'(1);
      idx_nxt        = idx;
      shd_val_nxt    = shd_val;
      shd_dp_nxt     = shd_dp;
      pending_nxt    = pending;
      disp_val_nxt   = disp_val;
      disp_dp_nxt    = disp_dp;
      frame_done_nxt = commit_c;
      an_nxt         = '1;
      seg_nxt        = SEG_BLANK;
      dp_n_nxt       = 1'b1;

      if (tick_c) begin
         idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end

      if (load) begin
         shd_val_nxt = value;
         shd_dp_nxt  = dp_in;
         pending_nxt = 1'b1;
      end

      // A load coinciding with commit bypasses the shadow register
      if (commit_c) begin
         pending_nxt = 1'b0;
         if (load) begin
            disp_val_nxt = value;
            disp_dp_nxt  = dp_in;
         end else if (pending) begin
            disp_val_nxt = shd_val;
            disp_dp_nxt  = shd_dp;
         end
      end

      if (enable) begin
         an_nxt   = ~(NUM_DIGITS'(1) << idx);
         seg_nxt  = glyph_c;
         dp_n_nxt = ~disp_dp[idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= '0;
         shd_val    <= '0;
         shd_dp     <= '0;
         pending    <= 1'b0;
         disp_val   <= '0;
         disp_dp    <= '0;
         seg        <= SEG_BLANK;
         dp_n       <= 1'b1;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         shd_val    <= shd_val_nxt;
         shd_dp     <= shd_dp_nxt;
         pending    <= pending_nxt;
         disp_val   <= disp_val_nxt;
         disp_dp    <= disp_dp_nxt;
         seg        <= seg_nxt;
         dp_n       <= dp_n_nxt;
         an         <= an_nxt;
         frame_done <= frame_done_nxt;
      end
   end

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Bench for sevenseg_mux_driver: BCD and hex instances side by side, a frame-level
// reference model, a glyph vector table and hand-written corner sequences.
module tb_sevenseg_mux_driver;

   localparam int N  = 4;
   localparam int RD = 4;
   localparam int FR = N * RD;
   localparam logic [6:0] B = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic        enable = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [6:0]  seg0, seg1;
   logic        dpn0, dpn1, fd0, fd1;
   logic [3:0]  an0, an1;

   int n_chk = 0;
   int n_pass = 0;

   // reference model state: edges since reset release, displayed and shadowed value
   int          m_e;
   logic [15:0] m_dval, m_sval;
   logic [3:0]  m_ddp, m_sdp;
   bit          m_pend;
   int          last_d;

   typedef struct packed {
      logic [15:0]      value;
      logic [3:0]       dp;
      logic [3:0][6:0]  sbcd;
      logic [3:0][6:0]  shex;
      logic [3:0]       dpn;
   } vec_t;
   vec_t vecs[6];

   sevenseg_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(0), .BLANK_LEADING(1)) dut_bcd (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in), .enable(enable),
      .seg(seg0), .dp_n(dpn0), .an(an0), .frame_done(fd0));

   sevenseg_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(1), .BLANK_LEADING(1)) dut_hex (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in), .enable(enable),
      .seg(seg1), .dp_n(dpn1), .an(an1), .frame_done(fd1));

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph_ref(int n);
      case (n)
         0: return 7'b0000001;   1: return 7'b1001111;   2: return 7'b0010010;
         3: return 7'b0000110;   4: return 7'b1001100;   5: return 7'b0100100;
         6: return 7'b0100000;   7: return 7'b0001111;   8: return 7'b0000000;
         9: return 7'b0000100;  10: return 7'b0001000;  11: return 7'b1100000;
        12: return 7'b0110001;  13: return 7'b1000010;  14: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(logic [15:0] v, int d, bit hex);
      int n;
      n = int'((v >> (4*d)) & 16'h000F);
      if (d > 0 && (v >> (4*d)) == 16'h0) return B;
      if (n > 9 && !hex) return B;
      return glyph_ref(n);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at edge %0d: got %0h expected %0h", name, m_e, act, exp);
   endtask

   task automatic model_reset();
      m_e = 0; m_dval = '0; m_sval = '0; m_ddp = '0; m_sdp = '0; m_pend = 0; last_d = 0;
   endtask

   // one clock: predict from the pre-edge state, advance the model, compare at negedge
   task automatic step();
      logic [3:0] e_an;
      logic [6:0] e_s0, e_s1;
      logic       e_dpn;
      bit         commit;
      int         d;
      d = (m_e / RD) % N;
      if (enable) begin
         e_an  = ~(4'(1) << d);
         e_s0  = exp_seg(m_dval, d, 0);
         e_s1  = exp_seg(m_dval, d, 1);
         e_dpn = ~m_ddp[d];
      end else begin
         e_an = 4'hF; e_s0 = B; e_s1 = B; e_dpn = 1'b1;
      end
      commit = ((m_e + 1) % FR) == 0;
      if (commit) begin
         if (load) begin
            m_dval = value; m_ddp = dp_in; m_pend = 0;
         end else if (m_pend) begin
            m_dval = m_sval; m_ddp = m_sdp; m_pend = 0;
         end
      end else if (load) begin
         m_sval = value; m_sdp = dp_in; m_pend = 1;
      end
      m_e++;
      @(posedge clk);
      @(negedge clk);
      chk("an", an0, e_an);
      chk("seg_bcd", seg0, e_s0);
      chk("seg_hex", seg1, e_s1);
      chk("dp_n", dpn0, e_dpn);
      chk("frame_done", fd0, commit);
      last_d = d;
   endtask

   // called at a negedge; asserts reset asynchronously and releases it two cycles later
   task automatic do_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      model_reset();
      #1;
      chk("rst_an", an0, 4'hF);
      chk("rst_seg", seg0, B);
      chk("rst_dp_n", dpn0, 1);
      chk("rst_frame_done", fd0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_val(logic [15:0] v, logic [3:0] dp);
      value = v; dp_in = dp; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic wait_commit();
      bit seen;
      seen = 0;
      for (int k = 0; k < 2*FR + 2; k++) begin
         step();
         if (fd0) begin seen = 1; break; end
      end
      chk("commit_seen", seen, 1);
   endtask

   task automatic run_to_idx(int target);
      for (int k = 0; k < FR; k++) begin
         if ((m_e / RD) % N == target) break;
         step();
      end
   endtask

   task automatic run_vec(vec_t v);
      load_val(v.value, v.dp);
      wait_commit();
      for (int k = 0; k < FR; k++) begin
         step();
         chk("vec_seg_bcd", seg0, v.sbcd[last_d]);
         chk("vec_seg_hex", seg1, v.shex[last_d]);
         chk("vec_dp_n", dpn0, v.dpn[last_d]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd_at, pulses;
      logic [15:0] mask;

      vecs[0] = '{16'h1234, 4'b0000, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                  {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111};
      vecs[1] = '{16'h0050, 4'b0100, {B, B, 7'b0100100, 7'b0000001},
                  {B, B, 7'b0100100, 7'b0000001}, 4'b1011};
      vecs[2] = '{16'h0000, 4'b0000, {B, B, B, 7'b0000001}, {B, B, B, 7'b0000001}, 4'b1111};
      vecs[3] = '{16'h00AF, 4'b0001, {B, B, B, B}, {B, B, 7'b0001000, 7'b0111000}, 4'b1110};
      vecs[4] = '{16'h8096, 4'b1000, {7'b0000000, 7'b0000001, 7'b0000100, 7'b0100000},
                  {7'b0000000, 7'b0000001, 7'b0000100, 7'b0100000}, 4'b0111};
      vecs[5] = '{16'hBCDE, 4'b0110, {B, B, B, B},
                  {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}, 4'b1001};

      @(negedge clk);
      do_reset();

      // first edge shows digit 0; first frame_done on edge 16
      fd_at = 0;
      for (int k = 1; k <= FR + 4; k++) begin
         step();
         if (k == 1) begin
            chk("first_an", an0, 4'b1110);
            chk("first_seg", seg0, 7'b0000001);
         end
         if (fd0 && fd_at == 0) fd_at = k;
      end
      chk("first_frame_done_edge", fd_at, FR);

      foreach (vecs[i]) run_vec(vecs[i]);

      // tear-free: a load at idx 1 must not disturb the rest of the 1234 frame
      run_vec(vecs[0]);
      run_to_idx(1);
      load_val(16'h5678, 4'b0000);
      for (int k = 0; k < 2*FR; k++) begin
         step();
         chk("tear_free", seg0, exp_seg(16'h1234, last_d, 0));
         if (fd0) break;
      end
      for (int k = 0; k < FR; k++) begin
         step();
         chk("after_commit_5678", seg0, exp_seg(16'h5678, last_d, 0));
      end

      // load exactly on the commit edge goes straight to the display
      for (int k = 0; k < FR; k++) begin
         if ((m_e + 1) % FR == 0) break;
         step();
      end
      load_val(16'h1111, 4'b0000);
      chk("load_at_commit_fd", fd0, 1);
      for (int k = 0; k < 2*FR; k++) begin
         step();
         chk("load_at_commit_val", seg0, exp_seg(16'h1111, last_d, 0));
      end

      // dark display while frame_done keeps pulsing
      run_to_idx(2);
      enable = 1'b0;
      step();
      chk("disable_an", an0, 4'hF);
      pulses = 0;
      for (int k = 0; k < 2*FR; k++) begin
         step();
         if (fd0) pulses++;
      end
      chk("fd_while_dark", pulses, 2);
      enable = 1'b1;

      // reset with a pending load: the pending value must never appear
      run_to_idx(1);
      load_val(16'h9999, 4'b1111);
      step();
      do_reset();
      for (int k = 0; k < 3*FR; k++) begin
         step();
         chk("post_reset_seg", seg0, exp_seg(16'h0000, last_d, 0));
         chk("post_reset_dp_n", dpn0, 1);
      end

      // randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         case ($urandom_range(0, 3))
            0: mask = 16'hFFFF;
            1: mask = 16'h0FFF;
            2: mask = 16'h00FF;
            default: mask = 16'h000F;
         endcase
         value  = 16'($urandom) & mask;
         dp_in  = 4'($urandom);
         load   = ($urandom_range(0, 7) == 0);
         enable = ($urandom_range(0, 15) != 0);
         step();
         load = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
